// File: rtl/bsg_axil_txs_stream.sv
// AXI4-Lite write slave that steers register writes into per-slot TX streams.
// AW and W may arrive in either order or together; stream backpressure is
// honoured with a bounded wait that ends in SLVERR.
module bsg_axil_txs_stream #(
  parameter int          num_fifos_p       = 4,
  parameter int          data_width_p      = 32,
  parameter int          base_addr_width_p = 12,
  parameter logic [31:0] slot_base_addr_p  = 32'h0000_1000,
  parameter logic [31:0] tdr_ofs_p         = 32'h10,
  parameter logic [31:0] isr_ofs_p         = 32'h00,
  parameter int          isr_txc_bit_p     = 27,
  parameter int          timeout_p         = 255
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [31:0]                       awaddr_i,
  input  logic                              awvalid_i,
  output logic                              awready_o,
  input  logic [data_width_p-1:0]           wdata_i,
  input  logic [data_width_p/8-1:0]         wstrb_i,
  input  logic                              wvalid_i,
  output logic                              wready_o,
  output logic [1:0]                        bresp_o,
  output logic                              bvalid_o,
  input  logic                              bready_i,
  output logic [num_fifos_p*data_width_p-1:0] txs_o,
  output logic [num_fifos_p-1:0]            txs_v_o,
  input  logic [num_fifos_p-1:0]            txs_ready_i,
  output logic [num_fifos_p-1:0]            clr_isrs_txc_o
);

  localparam int strb_width_lp = data_width_p / 8;
  localparam int cnt_width_lp  = $clog2(timeout_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(timeout_p - 1);

  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;
  localparam logic [1:0] resp_decerr = 2'b11;

  typedef enum logic [1:0] {IDLE, DISPATCH, RESP} state_e;

  state_e                    state_r, state_n;
  logic                      aw_v_r, aw_v_n, w_v_r, w_v_n;
  logic [31:0]               addr_r, addr_n;
  logic [data_width_p-1:0]   data_r, data_n;
  logic [strb_width_lp-1:0]  strb_r, strb_n;
  logic [1:0]                bresp_r, bresp_n;
  logic [cnt_width_lp-1:0]   cnt_r, cnt_n;

  logic [31:0]               slot_ofs, slot;
  logic                      hit, is_tdr, is_isr, full_strb, ready_hit;
  logic [num_fifos_p-1:0]    sel;
  logic                      aw_hs, w_hs;

  // Decode the captured address into a one-hot slot select.
  always_comb begin
    slot_ofs  = addr_r - slot_base_addr_p;
    slot      = slot_ofs >> base_addr_width_p;
    hit       = (addr_r >= slot_base_addr_p) && (slot < 32'(num_fifos_p));
    is_tdr    = addr_r[base_addr_width_p-1:0] == tdr_ofs_p[base_addr_width_p-1:0];
    is_isr    = addr_r[base_addr_width_p-1:0] == isr_ofs_p[base_addr_width_p-1:0];
    full_strb = &strb_r;
    sel       = '0;
    for (int unsigned i = 0; i < num_fifos_p; i++)
      if (hit && slot == 32'(i)) sel[i] = 1'b1;
    ready_hit = |(txs_ready_i & sel);
  end

  // State and payload registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      aw_v_r  <= 1'b0;
      w_v_r   <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      strb_r  <= '0;
      bresp_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      aw_v_r  <= aw_v_n;
      w_v_r   <= w_v_n;
      addr_r  <= addr_n;
      data_r  <= data_n;
      strb_r  <= strb_n;
      bresp_r <= bresp_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state, capture and handshake outputs.
  always_comb begin
    state_n        = state_r;
    aw_v_n         = aw_v_r;
    w_v_n          = w_v_r;
    addr_n         = addr_r;
    data_n         = data_r;
    strb_n         = strb_r;
    bresp_n        = bresp_r;
    cnt_n          = cnt_r;
    awready_o      = 1'b0;
    wready_o       = 1'b0;
    bvalid_o       = 1'b0;
    txs_v_o        = '0;
    clr_isrs_txc_o = '0;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
    unique case (state_r)
      IDLE: begin
        // readies are held low while reset is asserted
        awready_o = ~aw_v_r & reset_n_i;
        wready_o  = ~w_v_r & reset_n_i;
        aw_hs     = awvalid_i & awready_o;
        w_hs      = wvalid_i & wready_o;
        if (aw_hs) begin
          addr_n = awaddr_i;
          aw_v_n = 1'b1;
        end
        if (w_hs) begin
          data_n = wdata_i;
          strb_n = wstrb_i;
          w_v_n  = 1'b1;
        end
        if ((aw_v_r | aw_hs) && (w_v_r | w_hs)) begin
          aw_v_n  = 1'b0;
          w_v_n   = 1'b0;
          state_n = DISPATCH;
        end
      end
      DISPATCH: begin
        if (!hit) begin
          bresp_n = resp_decerr;
          state_n = RESP;
        end else if (is_tdr) begin
          if (!full_strb) begin
            bresp_n = resp_slverr;
            state_n = RESP;
          end else begin
            txs_v_o = sel;
            // a ready in the final wait cycle still completes with OKAY
            if (ready_hit) begin
              bresp_n = resp_okay;
              state_n = RESP;
            end else begin
              cnt_n = cnt_r + cnt_width_lp'(1);
              if (cnt_r == cnt_last_lp) begin
                bresp_n = resp_slverr;
                state_n = RESP;
              end
            end
          end
        end else if (is_isr) begin
          clr_isrs_txc_o = sel & {num_fifos_p{data_r[isr_txc_bit_p]}};
          bresp_n        = resp_okay;
          state_n        = RESP;
        end else begin
          bresp_n = resp_okay;
          state_n = RESP;
        end
      end
      RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bresp_o = bresp_r;
  assign txs_o   = {num_fifos_p{data_r}};

endmodule
